seven_seg_scanner: RTL

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_pkg.sv | 37 +++
 rtl/seven_seg_decode.sv | 11 +
 rtl/seven_seg_scanner.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared glyph table, blank code and nibble helpers for the scanner
package seven_seg_pkg;

  // All segments dark (active-low glyph bus).
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low glyphs, bit6..0 = g..a, indexed by the normalised nibble.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Map a raw input nibble to the digit it represents.
  function automatic logic [3:0] norm_nibble(input logic [3:0] nib, input bit inv);
    return inv ? ~nib : nib;
  endfunction

  // Raw nibble that displays as zero.
  function automatic logic [3:0] zero_code(input bit inv);
    return inv ? 4'hF : 4'h0;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// rtl/seven_seg_decode.sv - combinational normalised-nibble to active-low glyph lookup
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed seven-segment scanner with tear-free double buffering
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_CYC     = 16,
  parameter int NIBBLE_INV    = 1,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic                  enable,
  output logic [6:0]            segment,
  output logic                  dp,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_done
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam bit INV    = (NIBBLE_INV != 0);
  localparam logic [3:0] ZNIB = zero_code(INV);
  localparam logic [DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [SLOT_W-1:0]   slot_cnt;
  logic [IDX_W-1:0]    idx;
  logic                pending;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] disp_val;
  logic [DIGITS-1:0]   disp_dp;

  logic                slot_last;
  logic                idx_last;
  logic                boundary;
  logic [DIGITS-1:0]   supp;
  logic                run;
  logic [3:0]          cur_nib;
  logic                cur_supp;
  logic                cur_dp;
  logic [6:0]          glyph;
  logic [DIGITS-1:0]   an_sel;

  assign slot_last = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
  assign idx_last  = (idx == IDX_W'(DIGITS - 1));
  assign boundary  = enable && slot_last && idx_last;

  // Leading-zero mask: walk down from the top digit while digits are zero with no dp lit.
  always_comb begin
    supp = '0;
    run  = lz_en;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run     = run && (norm_nibble(disp_val[4*i +: 4], INV) == 4'h0) && !disp_dp[i];
      supp[i] = run;
    end
  end

  // Select the digit currently being scanned.
  always_comb begin
    cur_nib  = norm_nibble(disp_val[4*int'(idx) +: 4], INV);
    cur_supp = supp[idx];
    cur_dp   = disp_dp[idx];
    an_sel   = AN_OFF ^ (DIGITS'(1) << idx);
  end

  seven_seg_decode u_decode (
    .nibble (cur_nib),
    .glyph  (glyph)
  );

  // Slot counter, digit index and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      slot_cnt   <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= slot_last && idx_last;
      if (slot_last) begin
        slot_cnt <= '0;
        idx      <= idx_last ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
    end
  end

  // Shadow capture and frame-aligned commit; while disabled every cycle acts as a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val <= {DIGITS{ZNIB}};
      shadow_dp  <= '0;
      disp_val   <= {DIGITS{ZNIB}};
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
      end
      if (!enable) begin
        if (load) begin
          disp_val <= value;
          disp_dp  <= dp_in;
        end else if (pending) begin
          disp_val <= shadow_val;
          disp_dp  <= shadow_dp;
        end
        pending <= 1'b0;
      end else if (boundary) begin
        if (pending) begin
          disp_val <= shadow_val;
          disp_dp  <= shadow_dp;
        end
        // A load landing on the boundary itself waits for the next frame.
        pending <= load;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Registered display outputs, one cycle behind the slot/index state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segment <= SEG_OFF;
      dp      <= 1'b1;
      anode   <= AN_OFF;
    end else if (!enable) begin
      segment <= SEG_OFF;
      dp      <= 1'b1;
      anode   <= AN_OFF;
    end else begin
      anode   <= (slot_cnt < SLOT_W'(BLANK_CYC)) ? AN_OFF : an_sel;
      segment <= cur_supp ? SEG_OFF : glyph;
      dp      <= cur_supp | ~cur_dp;
    end
  end

endmodule
